// File: rtl/sar_scan_ctrl.sv
// ---------------------------------------------------------------------------
// sar_scan_ctrl
//
// Multi-channel SAR conversion sequencer. Walks the set bits of a latched
// channel mask, closes the sample switch for SAMPLE_CYC bit-periods, then
// resolves RES bits MSB-first by binary search against the external
// comparator. Each {channel, code} result goes into a show-ahead FIFO.
//
// Ports:
//   ADC_CLKIN    clock, all state on the rising edge
//   ADC_RESET    asynchronous active-high reset
//   ADC_START    scan enable (level)
//   CFG_CONT     1 = wrap and rescan at end of mask, 0 = single scan
//   CFG_RATE     bit-period D = 2^CFG_RATE clocks
//   CFG_CH_MASK  channels to convert, latched at scan start / wrap
//   ADC_COMP     comparator, 1 = analog input >= ADC_DAC
//   ADC_CH_SEL   analog mux select (holds last channel in idle)
//   ADC_SAMPLE   sample switch closed
//   ADC_DAC      DAC trial code, 0 outside conversion
//   BUSY         sequencer not idle
//   DOUT_*       FIFO head (valid/ready, code, channel)
//   FIFO_LEVEL   FIFO occupancy
//   OVF          sticky overflow, cleared by CLR_OVF
// ---------------------------------------------------------------------------
module sar_scan_ctrl #(
    parameter int unsigned NCH        = 4,
    parameter int unsigned RES        = 10,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned SAMPLE_CYC = 4,
    localparam int unsigned CHW       = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int unsigned LVW       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             ADC_CLKIN,
    input  logic             ADC_RESET,
    input  logic             ADC_START,
    input  logic             CFG_CONT,
    input  logic [1:0]       CFG_RATE,
    input  logic [NCH-1:0]   CFG_CH_MASK,
    input  logic             ADC_COMP,
    output logic [CHW-1:0]   ADC_CH_SEL,
    output logic             ADC_SAMPLE,
    output logic [RES-1:0]   ADC_DAC,
    output logic             BUSY,
    output logic             DOUT_VALID,
    input  logic             DOUT_READY,
    output logic [RES-1:0]   DOUT_DATA,
    output logic [CHW-1:0]   DOUT_CH,
    output logic [LVW-1:0]   FIFO_LEVEL,
    output logic             OVF,
    input  logic             CLR_OVF
);

    // Counter must hold SAMPLE_CYC * 8 - 1 (longest sample phase at CFG_RATE=3).
    localparam int unsigned CNTW = $clog2(SAMPLE_CYC * 8 + 1);
    localparam int unsigned BW   = $clog2(RES);
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned EW   = CHW + RES;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SAMPLE  = 2'd1;
    localparam logic [1:0] ST_CONVERT = 2'd2;
    localparam logic [1:0] ST_STORE   = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [CHW-1:0]  ch_q, ch_d;
    logic [NCH-1:0]  mask_q, mask_d;
    logic [1:0]      rate_q, rate_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [RES-1:0]  code_q, code_d;

    logic [RES-1:0]  trial;
    logic [CHW-1:0]  low_ch;
    logic [CHW-1:0]  next_ch;
    logic            next_found;

    // Phase lengths are loaded minus one; the counter runs down to zero.
    function automatic logic [CNTW-1:0] sample_len(input logic [1:0] r);
        return (CNTW'(SAMPLE_CYC) << r) - CNTW'(1);
    endfunction

    function automatic logic [CNTW-1:0] step_len(input logic [1:0] r);
        return (CNTW'(1) << r) - CNTW'(1);
    endfunction

    assign trial = {{(RES-1){1'b0}}, 1'b1} << bit_q;

    // Lowest set bit of the live configuration mask (used at latch points).
    always_comb begin
        low_ch = '0;
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (CFG_CH_MASK[i]) begin
                low_ch = CHW'(i);
            end
        end
    end

    // Next set bit of the latched mask strictly above the current channel.
    always_comb begin
        next_ch    = '0;
        next_found = 1'b0;
        for (int i = 0; i < int'(NCH); i++) begin
            if (!next_found && mask_q[i] && (i > int'(ch_q))) begin
                next_ch    = CHW'(i);
                next_found = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Sequencer
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        mask_d  = mask_q;
        rate_d  = rate_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        code_d  = code_q;

        case (state_q)
            ST_IDLE: begin
                if (ADC_START && (CFG_CH_MASK != '0)) begin
                    mask_d  = CFG_CH_MASK;
                    rate_d  = CFG_RATE;
                    ch_d    = low_ch;
                    cnt_d   = sample_len(CFG_RATE);
                    state_d = ST_SAMPLE;
                end
            end

            ST_SAMPLE: begin
                if (cnt_q == '0) begin
                    cnt_d   = step_len(rate_q);
                    bit_d   = BW'(RES - 1);
                    code_d  = '0;
                    state_d = ST_CONVERT;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end

            ST_CONVERT: begin
                if (cnt_q == '0) begin
                    // Comparator is only trusted at the end of the settle period.
                    if (ADC_COMP) begin
                        code_d = code_q | trial;
                    end
                    if (bit_q == '0) begin
                        state_d = ST_STORE;
                    end else begin
                        bit_d = bit_q - BW'(1);
                        cnt_d = step_len(rate_q);
                    end
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end

            ST_STORE: begin
                if (!ADC_START) begin
                    state_d = ST_IDLE;
                end else if (next_found) begin
                    ch_d    = next_ch;
                    cnt_d   = sample_len(rate_q);
                    state_d = ST_SAMPLE;
                end else if (CFG_CONT && (CFG_CH_MASK != '0)) begin
                    mask_d  = CFG_CH_MASK;
                    rate_d  = CFG_RATE;
                    ch_d    = low_ch;
                    cnt_d   = sample_len(CFG_RATE);
                    state_d = ST_SAMPLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ADC_CLKIN or posedge ADC_RESET) begin
        if (ADC_RESET) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            mask_q  <= '0;
            rate_q  <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            mask_q  <= mask_d;
            rate_q  <= rate_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            code_q  <= code_d;
        end
    end

    assign ADC_CH_SEL = ch_q;
    assign ADC_SAMPLE = (state_q == ST_SAMPLE);
    assign ADC_DAC    = (state_q == ST_CONVERT) ? (code_q | trial) : '0;
    assign BUSY       = (state_q != ST_IDLE);

    // -----------------------------------------------------------------------
    // Result FIFO (show-ahead)
    // -----------------------------------------------------------------------
    logic [EW-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVW-1:0] level_q, level_d;
    logic           ovf_q, ovf_d;
    logic           push, pop, full, accept, ovf_set;
    logic [EW-1:0]  head;

    assign push    = (state_q == ST_STORE);
    assign pop     = DOUT_VALID && DOUT_READY;
    assign full    = (level_q == LVW'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot the push needs.
    assign accept  = push && (!full || pop);
    assign ovf_set = push && full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (accept) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        level_d = level_q + LVW'(accept) - LVW'(pop);
    end

    // New overflow wins over a same-cycle clear.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (CLR_OVF) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge ADC_CLKIN or posedge ADC_RESET) begin
        if (ADC_RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge ADC_CLKIN) begin
        if (accept) begin
            mem[wr_ptr_q] <= {ch_q, code_q};
        end
    end

    assign head       = mem[rd_ptr_q];
    assign DOUT_VALID = (level_q != '0);
    assign DOUT_DATA  = DOUT_VALID ? head[RES-1:0] : '0;
    assign DOUT_CH    = DOUT_VALID ? head[EW-1:RES] : '0;
    assign FIFO_LEVEL = level_q;
    assign OVF        = ovf_q;

endmodule

// File: tb/tb_sar_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sar_scan_ctrl
//
// Self-checking bench for sar_scan_ctrl. An analog comparator model drives
// ADC_COMP from per-channel input values; expected results are the ideal
// quantised inputs in ascending channel order, with timing from the
// per-conversion cycle formula.
// ---------------------------------------------------------------------------
module tb_sar_scan_ctrl;

    localparam int NCH = 4;
    localparam int RES = 10;
    localparam int FD  = 8;
    localparam int SC  = 4;
    localparam int CHW = 2;
    localparam int LVW = 4;
    localparam int MAXCODE = (1 << RES) - 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           cont;
    logic [1:0]     rate;
    logic [NCH-1:0] mask;
    logic           comp;
    logic [CHW-1:0] ch_sel;
    logic           sample;
    logic [RES-1:0] dac;
    logic           busy;
    logic           dvalid;
    logic           dready;
    logic [RES-1:0] ddata;
    logic [CHW-1:0] dch;
    logic [LVW-1:0] level;
    logic           ovf;
    logic           clr_ovf;

    int unsigned vin [NCH];
    int unsigned cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    int unsigned pop_ch[$];
    int unsigned pop_dat[$];
    int unsigned pop_cyc[$];
    int unsigned exp_ch[$];
    int unsigned exp_dat[$];

    sar_scan_ctrl #(
        .NCH        (NCH),
        .RES        (RES),
        .FIFO_DEPTH (FD),
        .SAMPLE_CYC (SC)
    ) dut (
        .ADC_CLKIN   (clk),
        .ADC_RESET   (rst),
        .ADC_START   (start),
        .CFG_CONT    (cont),
        .CFG_RATE    (rate),
        .CFG_CH_MASK (mask),
        .ADC_COMP    (comp),
        .ADC_CH_SEL  (ch_sel),
        .ADC_SAMPLE  (sample),
        .ADC_DAC     (dac),
        .BUSY        (busy),
        .DOUT_VALID  (dvalid),
        .DOUT_READY  (dready),
        .DOUT_DATA   (ddata),
        .DOUT_CH     (dch),
        .FIFO_LEVEL  (level),
        .OVF         (ovf),
        .CLR_OVF     (clr_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Comparator: analog input at or above the DAC level.
    assign comp = (vin[ch_sel] >= 32'(dac));

    // Record every accepted FIFO head (sampled mid-cycle, before the pop edge).
    always @(negedge clk) begin
        if (dvalid && dready) begin
            pop_ch.push_back(32'(dch));
            pop_dat.push_back(32'(ddata));
            pop_cyc.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned conv_len(input int unsigned r);
        return SC * (1 << r) + RES * (1 << r) + 1;
    endfunction

    // Ideal SAR result: largest code not above the input.
    function automatic int unsigned ideal_code(input int unsigned v);
        return (v > MAXCODE) ? MAXCODE : v;
    endfunction

    task automatic build_expect(input logic [NCH-1:0] m);
        exp_ch.delete();
        exp_dat.delete();
        for (int i = 0; i < NCH; i++) begin
            if (m[i]) begin
                exp_ch.push_back(i);
                exp_dat.push_back(ideal_code(vin[i]));
            end
        end
    endtask

    task automatic clear_pops();
        pop_ch.delete();
        pop_dat.delete();
        pop_cyc.delete();
    endtask

    task automatic check_pops(input string tag);
        check_eq({tag, "_count"}, pop_ch.size(), exp_ch.size());
        for (int k = 0; k < exp_ch.size() && k < pop_ch.size(); k++) begin
            check_eq($sformatf("%s_ch%0d", tag, k), pop_ch[k], exp_ch[k]);
            check_eq($sformatf("%s_code%0d", tag, k), pop_dat[k], exp_dat[k]);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        cont = 1'b0;
        rate = 2'd0;
        mask = '0;
        dready = 1'b1;
        clr_ovf = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input string tag, input int limit);
        for (int i = 0; i < limit && busy; i++) tick();
        check_eq({tag, "_idle"}, 32'(busy), 0);
    endtask

    // One single-mode scan; START is held until the last channel begins sampling.
    task automatic run_scan(input string tag, input logic [NCH-1:0] m, input logic [1:0] r,
                            input bit rand_ready, input bit check_timing);
        int unsigned t0;
        int last;
        last = 0;
        for (int i = 0; i < NCH; i++) if (m[i]) last = i;
        build_expect(m);
        clear_pops();
        mask = m;
        rate = r;
        cont = 1'b0;
        dready = 1'b1;
        start = 1'b1;
        tick();
        t0 = cyc;
        if (check_timing) begin
            check_eq({tag, "_start_sample"}, 32'(sample), 1);
            check_eq({tag, "_start_busy"}, 32'(busy), 1);
        end
        for (int i = 0; i < 4000 && !(32'(ch_sel) == last && sample); i++) begin
            if (rand_ready) dready = 1'($urandom_range(0, 1));
            tick();
        end
        start = 1'b0;
        for (int i = 0; i < 4000 && busy; i++) begin
            if (rand_ready) dready = 1'($urandom_range(0, 1));
            tick();
        end
        check_eq({tag, "_dur"}, cyc - t0, exp_ch.size() * conv_len(r));
        dready = 1'b1;
        repeat (FD + 4) tick();
        check_pops(tag);
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        for (int i = 0; i < NCH; i++) vin[i] = 0;
        do_reset();

        // Reset state
        check_eq("rst_ch_sel", 32'(ch_sel), 0);
        check_eq("rst_sample", 32'(sample), 0);
        check_eq("rst_dac", 32'(dac), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_valid", 32'(dvalid), 0);
        check_eq("rst_level", 32'(level), 0);
        check_eq("rst_ovf", 32'(ovf), 0);

        // Directed single scan
        vin[0] = 100; vin[1] = 1023; vin[2] = 0; vin[3] = 512;
        run_scan("single", 4'b1011, 2'd0, 1'b0, 1'b1);
        if (pop_cyc.size() == 3) begin
            check_eq("single_gap01", pop_cyc[1] - pop_cyc[0], conv_len(0));
            check_eq("single_gap12", pop_cyc[2] - pop_cyc[1], conv_len(0));
        end else begin
            check_eq("single_popn", pop_cyc.size(), 3);
        end
        repeat (40) tick();
        check_eq("single_no_extra", pop_ch.size(), 3);
        check_eq("single_busy_end", 32'(busy), 0);
        check_eq("single_ch_hold", 32'(ch_sel), 3);

        // Rate: D = 4
        vin[0] = 0;
        build_expect(4'b0001);
        clear_pops();
        mask = 4'b0001;
        rate = 2'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        begin
            int unsigned smp_n, busy_n, dac_n;
            int unsigned dac_at [64];
            smp_n = 0; busy_n = 0; dac_n = 0;
            for (int k = 0; k < 64; k++) begin
                dac_at[k] = 32'(dac);
                if (sample) smp_n++;
                if (busy) busy_n++;
                if (dac != '0) dac_n++;
                tick();
            end
            check_eq("rate_sample_len", smp_n, SC * 4);
            check_eq("rate_busy_len", busy_n, conv_len(2));
            check_eq("rate_dac_cycles", dac_n, RES * 4);
            check_eq("rate_dac_first", dac_at[16], 512);
            check_eq("rate_dac_hold", dac_at[19], 512);
            check_eq("rate_dac_step2", dac_at[20], 256);
            check_eq("rate_dac_last", dac_at[55], 1);
        end
        check_pops("rate");

        // Randomized single scans
        for (int it = 0; it < 6; it++) begin
            logic [NCH-1:0] m;
            for (int i = 0; i < NCH; i++) begin
                case ($urandom_range(0, 5))
                    0: vin[i] = 0;
                    1: vin[i] = MAXCODE;
                    default: vin[i] = $urandom_range(0, MAXCODE);
                endcase
            end
            m = NCH'($urandom_range(1, (1 << NCH) - 1));
            run_scan($sformatf("rnd%0d", it), m, 2'($urandom_range(0, 1)), 1'b1, 1'b0);
        end

        // Overflow in continuous mode with a stalled consumer
        vin[0] = 300;
        clear_pops();
        dready = 1'b0;
        cont = 1'b1;
        rate = 2'd0;
        mask = 4'b0001;
        start = 1'b1;
        for (int i = 0; i < 400 && level != LVW'(FD); i++) tick();
        check_eq("ovf_level_full", 32'(level), FD);
        check_eq("ovf_pre", 32'(ovf), 0);
        for (int i = 0; i < 60 && !ovf; i++) tick();
        check_eq("ovf_set", 32'(ovf), 1);
        check_eq("ovf_level_hold", 32'(level), FD);
        start = 1'b0;
        wait_idle("ovf", 200);
        check_eq("ovf_sticky", 32'(ovf), 1);
        exp_ch.delete();
        exp_dat.delete();
        for (int i = 0; i < FD; i++) begin
            exp_ch.push_back(0);
            exp_dat.push_back(300);
        end
        dready = 1'b1;
        repeat (FD + 4) tick();
        check_pops("ovf_drain");
        check_eq("ovf_empty", 32'(level), 0);
        check_eq("ovf_before_clr", 32'(ovf), 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check_eq("ovf_cleared", 32'(ovf), 0);

        // Stop mid-scan
        vin[0] = 777; vin[1] = 55;
        build_expect(4'b0001);
        clear_pops();
        cont = 1'b1;
        mask = 4'b0011;
        start = 1'b1;
        tick();
        for (int i = 0; i < 100 && !(dac != '0 && ch_sel == 2'd0); i++) tick();
        check_eq("stop_in_convert", 32'(dac != '0), 1);
        start = 1'b0;
        wait_idle("stop", 100);
        repeat (30) tick();
        check_pops("stop");
        check_eq("stop_ch_hold", 32'(ch_sel), 0);
        cont = 1'b0;

        // Reset mid-conversion with 3 buffered entries
        dready = 1'b0;
        cont = 1'b1;
        mask = 4'b1111;
        start = 1'b1;
        tick();
        for (int i = 0; i < 200 && !(level == 4'd3 && dac != '0); i++) tick();
        check_eq("mrst_pre_level", 32'(level), 3);
        #1;
        rst = 1'b1;
        #1;
        check_eq("mrst_ch_sel", 32'(ch_sel), 0);
        check_eq("mrst_sample", 32'(sample), 0);
        check_eq("mrst_dac", 32'(dac), 0);
        check_eq("mrst_busy", 32'(busy), 0);
        check_eq("mrst_valid", 32'(dvalid), 0);
        check_eq("mrst_data", 32'(ddata), 0);
        check_eq("mrst_dch", 32'(dch), 0);
        check_eq("mrst_level", 32'(level), 0);
        check_eq("mrst_ovf", 32'(ovf), 0);
        start = 1'b0;
        cont = 1'b0;
        dready = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Empty mask holds the sequencer idle
        vin[2] = 640;
        clear_pops();
        mask = '0;
        start = 1'b1;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (busy || sample) cnt++;
            tick();
        end
        check_eq("empty_idle", cnt, 0);
        mask = 4'b0100;
        build_expect(4'b0100);
        tick();
        check_eq("empty_then_sample", 32'(sample), 1);
        check_eq("empty_then_ch", 32'(ch_sel), 2);
        start = 1'b0;
        wait_idle("empty", 100);
        repeat (4) tick();
        check_pops("empty");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sar_scan_ctrl.md
# sar_scan_ctrl

Parametrised multi-channel SAR conversion sequencer for the ADC subsystem.
- Scans a programmable set of analog channels and drives the sample switch and the SAR DAC trial code.
- Resolves each sample by binary search against an external comparator bit.
- Queues tagged results in a FIFO with a valid/ready output port.
- Sits between the analog SAR macro (DAC, comparator, mux) and the peripheral register/DMA logic. Adds multi-channel scan, programmable resolution, continuous mode, buffering and overflow reporting.

## Interface
Parameters:
- NCH, 4, number of input channels (≥1); CHW = max(1, clog2(NCH))
- RES, 10, conversion resolution in bits (2..16)
- FIFO_DEPTH, 8, result FIFO entries (power of 2, ≥2)
- SAMPLE_CYC, 4, sample phase length in bit-periods (≥1)

Ports:
- ADC_CLKIN  in  1  clock, all logic on rising edge
- ADC_RESET  in  1  asynchronous, active-high reset
- ADC_START  in  1  scan enable (level)
- CFG_CONT  in  1  1 = continuous scan, 0 = single scan
- CFG_RATE  in  2  bit-period D = 2^CFG_RATE clocks
- CFG_CH_MASK  in  NCH  channels to convert
- ADC_COMP  in  1  comparator: 1 = input ≥ ADC_DAC
- ADC_CH_SEL  out  CHW  analog mux select
- ADC_SAMPLE  out  1  sample switch closed
- ADC_DAC  out  RES  DAC trial code
- BUSY  out  1  state ≠ IDLE
- DOUT_VALID  out  1  FIFO non-empty
- DOUT_READY  in  1  consumer accepts head entry
- DOUT_DATA  out  RES  head entry code
- DOUT_CH  out  CHW  head entry channel
- FIFO_LEVEL  out  clog2(FIFO_DEPTH)+1  occupancy
- OVF  out  1  sticky overflow
- CLR_OVF  in  1  synchronous clear of OVF

## Operation
- **States:** IDLE, SAMPLE, CONVERT, STORE.
- **IDLE:** when ADC_START=1 and CFG_CH_MASK≠0:
  - latch CFG_CH_MASK into scan_mask and CFG_RATE into rate;
  - set ch = lowest set bit;
  - go to SAMPLE next cycle.
  - With mask=0, remain in IDLE.
- **SAMPLE:**
  - ADC_SAMPLE=1 for SAMPLE_CYC·D cycles.
  - Then CONVERT with bit index RES-1 and ADC_DAC = 1<<(RES-1).
- **CONVERT:**
  - Each step lasts D cycles.
  - ADC_DAC = decided bits | current trial bit.
  - On the last cycle of a step, sample ADC_COMP: 1 keeps the trial bit, 0 clears it. Then set the next lower trial bit.
  - After bit 0 is decided, go to STORE.
  - ADC_DAC=0 outside CONVERT.
- **STORE (1 cycle):**
  - Push {ch, code} into the FIFO.
  - If the FIFO is full and no pop occurs this cycle, drop the entry and set OVF=1.
  - Next channel = next set bit of scan_mask above ch → SAMPLE.
  - If no set bit remains (end of scan):
    - if CFG_CONT=1 and ADC_START=1: re-latch mask and rate, wrap to the lowest set bit, go to SAMPLE (new mask=0 → IDLE);
    - otherwise go to IDLE.
- **ADC_START deasserted mid-scan:** the current conversion completes and is stored, then go to IDLE. No abort.
- **CFG_CH_MASK / CFG_RATE changes:** take effect only at the latch points listed above.
- **FIFO:**
  - Show-ahead. Pop when DOUT_VALID & DOUT_READY.
  - Push with simultaneous pop when full is accepted (no overflow).
  - Pop when empty is ignored.
- **OVF:** CLR_OVF=1 clears OVF. Clear and a new overflow in the same cycle → OVF=1.
- **ADC_CH_SEL:** holds ch, including in IDLE after a scan.

## Timing
- Reset values:
  - state IDLE; ADC_CH_SEL=0; ADC_SAMPLE=0; ADC_DAC=0; BUSY=0;
  - DOUT_VALID=0; DOUT_DATA=0; DOUT_CH=0; FIFO_LEVEL=0; OVF=0.
- All outputs are registered or decoded from registers; no combinational path from inputs to outputs.
- Start: ADC_START sampled high in IDLE at edge n → ADC_SAMPLE=1 and BUSY=1 from cycle n+1.
- Per conversion: SAMPLE_CYC·D + RES·D + 1 cycles, from SAMPLE entry through STORE.
  - Back-to-back channels have no gap cycle.
- DOUT_VALID rises the cycle after STORE when the FIFO was empty.
- FIFO_LEVEL updates on the same edge as push/pop.
- Reset asserted mid-operation immediately forces all reset values (asynchronous) and empties the FIFO.

## Test plan
Bench comparator model: ADC_COMP = (vin[ADC_CH_SEL] ≥ ADC_DAC).
- **Single scan:** NCH=4, RES=10, SAMPLE_CYC=4, CFG_RATE=0, mask=4'b1011, vin={100,1023,0,512}, DOUT_READY=1.
  - FIFO outputs (0,100), (1,1023), (3,512) in order, 15 cycles apart.
  - BUSY drops after the third STORE; no further entries.
- **Overflow:** CFG_CONT=1, mask=4'b0001, vin0=300, DOUT_READY=0.
  - FIFO_LEVEL reaches 8; the 9th STORE sets OVF=1 and the level stays 8.
  - Raise DOUT_READY: 8 entries of (0,300); CLR_OVF → OVF=0.
- **Rate:** CFG_RATE=2.
  - ADC_SAMPLE high exactly 16 cycles.
  - Each ADC_DAC step held 4 cycles; conversion 57 cycles.
  - vin=0 → code 0.
- **Stop mid-scan:** mask=4'b0011, continuous; drop ADC_START during CONVERT of ch0.
  - ch0 result is pushed, then IDLE; ch1 is not converted.
- **Reset mid-conversion:** assert ADC_RESET during CONVERT with 3 FIFO entries.
  - All outputs at reset values asynchronously; FIFO_LEVEL=0; OVF=0.
- **Empty mask:** mask=0, ADC_START=1.
  - BUSY stays 0 and ADC_SAMPLE stays 0 for 100 cycles.
  - Then set mask=4'b0100: conversion starts on ch2.
